// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter: one acc*10+digit step per digit, MSD first, start/done handshake.
// Optional macro BCD_DIGIT_CHECK_EN flags any digit above 9 as an error reported with done.
module bcd_to_bin #(
    parameter int unsigned NDIG = 3,
    parameter int unsigned BW   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] bcd,
    output logic              busy,
    output logic              done,
    output logic [BW-1:0]     bin,
    output logic              ovf,
    output logic              err
);
    localparam int unsigned AW = BW + 4;
    localparam int unsigned SW = AW + 4;
    localparam int unsigned CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t            state_q, state_d;
    logic [4*NDIG-1:0] opnd_q, opnd_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_run_q, ovf_run_d;
    logic [BW-1:0]     bin_q, bin_d;
    logic              ovf_q, ovf_d;
    logic [3:0]        digit;
    logic [SW-1:0]     step;
    logic              step_ovf;
    logic              err_now;

    // Operand shifts left each step so the digit being consumed is always in the MSBs.
    assign digit    = opnd_q[4*NDIG-1 -: 4];
    assign step     = {4'b0000, acc_q} * SW'(10) + SW'(digit);
    assign step_ovf = |step[SW-1:BW];

    always_comb begin
        state_d   = state_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_run_d = ovf_run_q;
        bin_d     = bin_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opnd_d    = bcd;
                    acc_d     = '0;
                    cnt_d     = '0;
                    ovf_run_d = 1'b0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                opnd_d    = opnd_q << 4;
                acc_d     = step[AW-1:0];
                cnt_d     = cnt_q + 1'b1;
                ovf_run_d = ovf_run_q | step_ovf;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    if (err_now) begin
                        bin_d = '0;
                        ovf_d = 1'b0;
                    end else if (ovf_run_d) begin
                        bin_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        bin_d = step[BW-1:0];
                        ovf_d = 1'b0;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_run_q <= 1'b0;
            bin_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_run_q <= ovf_run_d;
            bin_q     <= bin_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic err_run_q, err_run_d;
    logic err_q, err_d;

    assign err_now = err_run_q | (digit > 4'd9);

    always_comb begin
        err_run_d = err_run_q;
        err_d     = err_q;
        case (state_q)
            IDLE: if (start) err_run_d = 1'b0;
            CONV: begin
                err_run_d = err_now;
                if (cnt_q == LAST) err_d = err_now;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_run_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_run_q <= err_run_d;
            err_q     <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err_now = 1'b0;
    assign err     = 1'b0;
`endif

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign bin  = bin_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: NDIG=3 with BW=10 and BW=9 instances sharing clock and reset.
module tb_bcd_to_bin;
    localparam int unsigned NDIG = 3;
    localparam int unsigned BW   = 10;
    localparam int unsigned BW9  = 9;

    typedef struct packed {
        logic [9:0] bin;
        logic       ovf;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start9;
    logic [11:0] bcd, bcd9;
    logic        busy, done, ovf, err;
    logic [9:0]  bin;
    logic        busy9, done9, ovf9, err9;
    logic [8:0]  bin9;

    exp_t sb[$];
    exp_t sb9[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    bcd_to_bin #(.NDIG(NDIG), .BW(BW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .bcd(bcd),
        .busy(busy), .done(done), .bin(bin), .ovf(ovf), .err(err)
    );

    bcd_to_bin #(.NDIG(NDIG), .BW(BW9)) u_dut9 (
        .clk(clk), .rst(rst), .start(start9), .bcd(bcd9),
        .busy(busy9), .done(done9), .bin(bin9), .ovf(ovf9), .err(err9)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain decimal value of the three digits, then saturate / error-override.
    function automatic exp_t model(input logic [11:0] v, input int unsigned w);
        exp_t        r;
        int unsigned val;
        int unsigned mx;
        r   = '0;
        val = 100 * v[11:8] + 10 * v[7:4] + v[3:0];
        mx  = (1 << w) - 1;
`ifdef BCD_DIGIT_CHECK_EN
        if (v[11:8] > 9 || v[7:4] > 9 || v[3:0] > 9) begin
            r.err = 1'b1;
            return r;
        end
`endif
        if (val > mx) begin
            r.bin = 10'(mx);
            r.ovf = 1'b1;
        end else begin
            r.bin = 10'(val);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) check("unexpected_done", 32'(done), 0);
            else begin
                e = sb.pop_front();
                check("bin", 32'(bin), 32'(e.bin));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("err", 32'(err), 32'(e.err));
            end
        end
        if (done9) begin
            if (sb9.size() == 0) check("unexpected_done9", 32'(done9), 0);
            else begin
                e = sb9.pop_front();
                check("bin9", 32'(bin9), 32'(e.bin));
                check("ovf9", 32'(ovf9), 32'(e.ovf));
                check("err9", 32'(err9), 32'(e.err));
            end
        end
    end

    task automatic go(input bit w9, input logic [11:0] v);
        @(negedge clk);
        if (w9) begin
            bcd9 = v; start9 = 1'b1; sb9.push_back(model(v, BW9));
        end else begin
            bcd = v; start = 1'b1; sb.push_back(model(v, BW));
        end
        @(negedge clk);
        start = 1'b0;
        start9 = 1'b0;
    endtask

    task automatic wait_done(input bit w9, output int c);
        int k = 0;
        while (!(w9 ? done9 : done) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check(w9 ? "done9_seen" : "done_seen", w9 ? 32'(done9) : 32'(done), 1);
        c = cyc;
    endtask

    initial begin
        int lat, b, t_a, t_b;
        rst = 1'b1; start = 1'b0; start9 = 1'b0; bcd = '0; bcd9 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_bin",  32'(bin),  0);
        check("rst_ovf",  32'(ovf),  0);
        check("rst_err",  32'(err),  0);
        check("rst_busy9", 32'(busy9), 0);
        check("rst_bin9",  32'(bin9),  0);
        rst = 1'b0;

        // Zero operand: latency and busy length
        go(1'b0, 12'h000);
        lat = 1; b = 0;
        while (!done && lat < 20) begin
            if (busy) b++;
            @(negedge clk);
            lat++;
        end
        if (busy) b++;
        check("latency_000", 32'(lat), 4);
        check("busy_cycles_000", 32'(b), 4);
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        check("done_single", 32'(done), 0);

        // Back-to-back: 999 then immediate restart with 507
        go(1'b0, 12'h999);
        wait_done(1'b0, t_a);
        bcd = 12'h507; start = 1'b1; sb.push_back(model(12'h507, BW));
        @(negedge clk);
        check("held_bin_999", 32'(bin), 999);
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, t_b);
        check("done_spacing", 32'(t_b - t_a), 5);

        // Start held through CONV with new operand: ignored until IDLE
        @(negedge clk);
        bcd = 12'h123; start = 1'b1; sb.push_back(model(12'h123, BW));
        @(negedge clk);
        bcd = 12'h456; sb.push_back(model(12'h456, BW));
        wait_done(1'b0, t_a);
        @(negedge clk);
        check("idle_between", 32'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        check("held_start_taken", 32'(busy), 1);
        wait_done(1'b0, t_b);

        // Narrow instance: saturation, exact boundary, recovery
        go(1'b1, 12'h600); wait_done(1'b1, t_a);
        go(1'b1, 12'h042); wait_done(1'b1, t_a);
        go(1'b1, 12'h511); wait_done(1'b1, t_a);
        go(1'b1, 12'h512); wait_done(1'b1, t_a);

        // Non-decimal digits
        go(1'b0, 12'h1A3); wait_done(1'b0, t_a);
        go(1'b0, 12'hFFF); wait_done(1'b0, t_a);
        go(1'b0, 12'h100); wait_done(1'b0, t_a);

        // Reset during the second CONV cycle of 777
        go(1'b0, 12'h777);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_bin",  32'(bin),  0);
        check("abort_ovf",  32'(ovf),  0);
        check("abort_err",  32'(err),  0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("no_done_after_abort", 32'(done), 0);
        end
        go(1'b0, 12'h250); wait_done(1'b0, t_a);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 0);
        check("sb9_drained", 32'(sb9.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
